// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped predictor combining 2-bit counters with a
// tagged BTB, indexed bimodally or gshare-style.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   PCF                 - fetch PC to predict
//   predict_taken_F     - combinational taken prediction for PCF
//   predicted_target_F  - BTB target when predicted taken, else PCF+4
//   ghr_F               - global history used for this lookup
//   update_*_E          - resolved conditional branch from execute
//   mispredict_E        - that branch resolved opposite to its prediction
//   branch_count        - saturating count of resolved branches
//   mispredict_count    - saturating count of mispredicts
module branch_predictor #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned HIST_BITS = 6,
  parameter bit          GSHARE    = 1'b1,
  parameter int unsigned TAG_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          PCF,
  output logic                 predict_taken_F,
  output logic [31:0]          predicted_target_F,
  output logic [HIST_BITS-1:0] ghr_F,
  input  logic                 update_en_E,
  input  logic [31:0]          update_pc_E,
  input  logic [HIST_BITS-1:0] update_ghr_E,
  input  logic                 update_taken_E,
  input  logic [31:0]          update_target_E,
  input  logic                 mispredict_E,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  logic [1:0]          ctr_q    [ENTRIES];
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q;
  logic [31:0]         branch_count_q;
  logic [31:0]         mispredict_count_q;

  logic [IDX-1:0]      lk_idx;
  logic [IDX-1:0]      up_idx;
  logic                lk_hit;

  // Table index: word-aligned PC bits, optionally hashed with history
  function automatic logic [IDX-1:0] index_of(input logic [31:0] pc,
                                              input logic [HIST_BITS-1:0] ghr);
    logic [IDX-1:0] idx;
    idx = pc[IDX+1:2];
    if (GSHARE) idx = idx ^ IDX'(ghr);
    return idx;
  endfunction

  // Tag: PC bits just above the index; bits past 31 shift in as zero
  function automatic logic [TAG_BITS-1:0] tag_of(input logic [31:0] pc);
    return TAG_BITS'(pc >> (IDX + 2));
  endfunction

  assign lk_idx = index_of(PCF, ghr_q);
  assign up_idx = index_of(update_pc_E, update_ghr_E);

  // Lookup reads only registered state, so a same-cycle update is not visible
  assign lk_hit             = valid_q[lk_idx] && (tag_q[lk_idx] == tag_of(PCF));
  assign predict_taken_F    = lk_hit && ctr_q[lk_idx][1];
  assign predicted_target_F = predict_taken_F ? target_q[lk_idx] : PCF + 32'd4;
  assign ghr_F              = ghr_q;
  assign branch_count       = branch_count_q;
  assign mispredict_count   = mispredict_count_q;

  // Saturating direction counters and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[IDX'(i)] <= 2'b01;
      end
      valid_q <= '0;
    end else if (update_en_E) begin
      if (update_taken_E) begin
        valid_q[up_idx] <= 1'b1;
        if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
      end else if (ctr_q[up_idx] != 2'b00) begin
        ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
      end
    end
  end

  // BTB tag/target storage; left unreset because valid masks stale contents
  always_ff @(posedge clk) begin
    if (rst_n && update_en_E && update_taken_E) begin
      tag_q[up_idx]    <= tag_of(update_pc_E);
      target_q[up_idx] <= update_target_E;
    end
  end

  // Non-speculative global history, shifted only by resolved branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (update_en_E) begin
      ghr_q <= HIST_BITS'({ghr_q, update_taken_E});
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (update_en_E) begin
      if (branch_count_q != 32'hFFFF_FFFF) branch_count_q <= branch_count_q + 32'd1;
      if (mispredict_E && (mispredict_count_q != 32'hFFFF_FFFF)) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share stimulus;
// directed vectors push expected values into a queue, and a negedge monitor
// pops and compares them against the selected instance's outputs.
module tb_branch_predictor;

  localparam int F_TAKEN  = 0;
  localparam int F_TARGET = 1;
  localparam int F_GHR    = 2;
  localparam int F_BC     = 3;
  localparam int F_MC     = 4;
  localparam int BIM      = 0;
  localparam int GS       = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        update_en_E;
  logic [31:0] update_pc_E;
  logic [5:0]  update_ghr_E;
  logic        update_taken_E;
  logic [31:0] update_target_E;
  logic        mispredict_E;

  logic        bim_taken, gs_taken;
  logic [31:0] bim_target, gs_target;
  logic [5:0]  bim_ghr, gs_ghr;
  logic [31:0] bim_bc, gs_bc, bim_mc, gs_mc;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .HIST_BITS(6), .GSHARE(1'b0), .TAG_BITS(8)) u_bim (
    .clk(clk), .rst_n(rst_n), .PCF(PCF),
    .predict_taken_F(bim_taken), .predicted_target_F(bim_target), .ghr_F(bim_ghr),
    .update_en_E(update_en_E), .update_pc_E(update_pc_E), .update_ghr_E(update_ghr_E),
    .update_taken_E(update_taken_E), .update_target_E(update_target_E),
    .mispredict_E(mispredict_E), .branch_count(bim_bc), .mispredict_count(bim_mc)
  );

  branch_predictor #(.ENTRIES(64), .HIST_BITS(6), .GSHARE(1'b1), .TAG_BITS(8)) u_gs (
    .clk(clk), .rst_n(rst_n), .PCF(PCF),
    .predict_taken_F(gs_taken), .predicted_target_F(gs_target), .ghr_F(gs_ghr),
    .update_en_E(update_en_E), .update_pc_E(update_pc_E), .update_ghr_E(update_ghr_E),
    .update_taken_E(update_taken_E), .update_target_E(update_target_E),
    .mispredict_E(mispredict_E), .branch_count(gs_bc), .mispredict_count(gs_mc)
  );

  typedef struct {
    string       name;
    int          sel;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sel, input int fld);
    logic [31:0] a;
    a = '0;
    case (fld)
      F_TAKEN:  a = (sel == BIM) ? 32'(bim_taken) : 32'(gs_taken);
      F_TARGET: a = (sel == BIM) ? bim_target     : gs_target;
      F_GHR:    a = (sel == BIM) ? 32'(bim_ghr)   : 32'(gs_ghr);
      F_BC:     a = (sel == BIM) ? bim_bc         : gs_bc;
      F_MC:     a = (sel == BIM) ? bim_mc         : gs_mc;
      default:  a = 32'hDEAD_DEAD;
    endcase
    return a;
  endfunction

  // Monitor: compare every queued expectation at the negedge of its cycle
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.sel, e.fld);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s (dut%0d field%0d): got %h expected %h", e.name, e.sel, e.fld, a, e.val);
      end
    end
  end

  task automatic expect_val(input int sel, input string name, input int fld, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.fld  = fld;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_pred(input int sel, input string name, input bit taken, input logic [31:0] tgt);
    expect_val(sel, {name, "_taken"}, F_TAKEN, 32'(taken));
    expect_val(sel, {name, "_target"}, F_TARGET, tgt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] g, input bit taken,
                     input logic [31:0] tgt, input bit mis);
    update_en_E     = 1'b1;
    update_pc_E     = pc;
    update_ghr_E    = g;
    update_taken_E  = taken;
    update_target_E = tgt;
    mispredict_E    = mis;
    step();
    update_en_E  = 1'b0;
    mispredict_E = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    PCF             = 32'h100;
    update_en_E     = 1'b0;
    update_pc_E     = '0;
    update_ghr_E    = '0;
    update_taken_E  = 1'b0;
    update_target_E = '0;
    mispredict_E    = 1'b0;

    // In reset: not taken, fall-through target
    step();
    expect_pred(BIM, "in_reset_bim", 1'b0, 32'h104);
    expect_pred(GS,  "in_reset_gs",  1'b0, 32'h104);
    step();
    rst_n = 1'b1;
    expect_pred(BIM, "post_reset", 1'b0, 32'h104);
    expect_val(BIM, "post_reset_ghr", F_GHR, 32'h0);
    expect_val(GS,  "post_reset_ghr_gs", F_GHR, 32'h0);
    expect_val(BIM, "post_reset_bc", F_BC, 32'h0);
    expect_val(BIM, "post_reset_mc", F_MC, 32'h0);
    step();

    // Bimodal training; same-cycle lookup sees pre-update state
    update_en_E = 1'b1; update_pc_E = 32'h100; update_ghr_E = 6'h0;
    update_taken_E = 1'b1; update_target_E = 32'h80;
    expect_pred(BIM, "same_cycle", 1'b0, 32'h104);
    step();
    update_en_E = 1'b0;
    expect_pred(BIM, "taken1", 1'b1, 32'h80);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b0);
    expect_pred(BIM, "taken2", 1'b1, 32'h80);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b0);
    expect_val(BIM, "ghr_after_3t", F_GHR, 32'h7);
    expect_val(BIM, "bc_after_3t", F_BC, 32'd3);
    upd(32'h100, 6'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    expect_pred(BIM, "nt1_retain", 1'b1, 32'h80);
    upd(32'h100, 6'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    expect_pred(BIM, "nt2", 1'b0, 32'h104);
    upd(32'h100, 6'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    expect_pred(BIM, "nt3", 1'b0, 32'h104);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b0);
    expect_pred(BIM, "floor", 1'b0, 32'h104);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b0);
    expect_pred(BIM, "retrain", 1'b1, 32'h80);
    expect_val(BIM, "ghr_mixed", F_GHR, 32'h23);
    expect_val(BIM, "bc_8", F_BC, 32'd8);
    expect_val(BIM, "mc_0", F_MC, 32'd0);
    step();
    PCF = 32'h200;
    expect_pred(BIM, "alias", 1'b0, 32'h204);
    step();
    PCF = 32'h100;

    // Statistics saturation from preloaded values
    force u_bim.branch_count_q = 32'hFFFF_FFFE;
    force u_bim.mispredict_count_q = 32'hFFFF_FFFE;
    #1;
    release u_bim.branch_count_q;
    release u_bim.mispredict_count_q;
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b1);
    expect_val(BIM, "bc_max", F_BC, 32'hFFFF_FFFF);
    expect_val(BIM, "mc_max", F_MC, 32'hFFFF_FFFF);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b1);
    expect_val(BIM, "bc_sat", F_BC, 32'hFFFF_FFFF);
    expect_val(BIM, "mc_sat", F_MC, 32'hFFFF_FFFF);

    // Reset pulse mid-update: outputs drop immediately, update discarded
    step();
    update_en_E = 1'b1; update_pc_E = 32'h100; update_ghr_E = 6'h0;
    update_taken_E = 1'b1; update_target_E = 32'h80; mispredict_E = 1'b1;
    #2;
    rst_n = 1'b0;
    expect_pred(BIM, "async_rst", 1'b0, 32'h104);
    expect_val(BIM, "async_rst_ghr", F_GHR, 32'h0);
    expect_val(BIM, "async_rst_bc", F_BC, 32'h0);
    expect_val(BIM, "async_rst_mc", F_MC, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    update_en_E = 1'b0; mispredict_E = 1'b0;
    expect_val(BIM, "first_upd_bc", F_BC, 32'd1);
    expect_val(BIM, "first_upd_mc", F_MC, 32'd1);
    expect_val(BIM, "first_upd_ghr", F_GHR, 32'h1);
    expect_pred(BIM, "first_upd", 1'b1, 32'h80);
    mispredict_E = 1'b1;
    step();
    mispredict_E = 1'b0;
    expect_val(BIM, "mis_ignored_mc", F_MC, 32'd1);
    expect_val(BIM, "mis_ignored_bc", F_BC, 32'd1);
    upd(32'h100, 6'h0, 1'b1, 32'h80, 1'b0);
    expect_val(BIM, "bc_2", F_BC, 32'd2);
    expect_val(BIM, "mc_still_1", F_MC, 32'd1);

    // Gshare: update index uses update_ghr_E, not the live history
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    upd(32'h100, 6'b000001, 1'b1, 32'h80, 1'b0);
    expect_val(GS, "gs_ghr1", F_GHR, 32'h1);
    upd(32'h100, 6'b000000, 1'b1, 32'hC0, 1'b0);
    expect_val(GS, "gs_ghr3", F_GHR, 32'h3);
    upd(32'h100, 6'b000000, 1'b1, 32'hC0, 1'b0);
    expect_val(GS, "gs_ghr7", F_GHR, 32'h7);
    PCF = 32'h11C;
    expect_pred(GS, "gs_idx0", 1'b1, 32'hC0);
    step();
    PCF = 32'h118;
    expect_pred(GS, "gs_idx1", 1'b1, 32'h80);
    step();
    PCF = 32'h100;
    expect_pred(GS, "gs_idx7", 1'b0, 32'h104);
    step();

    // Drain with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, meaning the number of table entries; it must be a power of two, 4..1024. IDX = log2(ENTRIES).
REQ-002 The block SHALL have parameter HIST_BITS, default 6, meaning the global history length; range 1..IDX.
REQ-003 The block SHALL have parameter GSHARE, default 1, meaning index mode: 0 selects bimodal, 1 selects gshare.
REQ-004 The block SHALL have parameter TAG_BITS, default 8, meaning the BTB tag width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n, listed first.
REQ-006 The block SHALL provide the port: clk  input  1  rising-edge clock.
REQ-007 The block SHALL provide the port: rst_n  input  1  asynchronous active-low reset.
REQ-008 The block SHALL provide the port: PCF  input  32  fetch-stage PC to predict.
REQ-009 The block SHALL provide the port: predict_taken_F  output  1  predicted taken for PCF.
REQ-010 The block SHALL provide the port: predicted_target_F  output  32  predicted target for PCF.
REQ-011 The block SHALL provide the port: ghr_F  output  HIST_BITS  history used for this lookup; the pipeline carries it to execute.
REQ-012 The block SHALL provide the port: update_en_E  input  1  a resolved conditional branch is in execute.
REQ-013 The block SHALL provide the port: update_pc_E  input  32  PC of the resolved branch.
REQ-014 The block SHALL provide the port: update_ghr_E  input  HIST_BITS  ghr_F value that travelled with that branch.
REQ-015 The block SHALL provide the port: update_taken_E  input  1  actual outcome of the branch.
REQ-016 The block SHALL provide the port: update_target_E  input  32  actual branch target address.
REQ-017 The block SHALL provide the port: mispredict_E  input  1  the branch resolved opposite to its prediction.
REQ-018 The block SHALL provide the port: branch_count  output  32  number of resolved branches, saturating.
REQ-019 The block SHALL provide the port: mispredict_count  output  32  number of mispredicts, saturating.

Function
REQ-020 Lookup index SHALL be PCF[IDX+1:2], XORed with the zero-extended ghr when GSHARE=1.
REQ-021 The tag SHALL be PC[IDX+1+TAG_BITS:IDX+2]; bits above bit 31 read as 0.
REQ-022 Each entry SHALL hold a 2-bit saturating counter, a valid bit, a tag and a 32-bit target.
REQ-023 Lookup SHALL be combinational from registered state: predict_taken_F = valid && tag match && counter[1].
REQ-024 predicted_target_F SHALL equal the entry target when predict_taken_F=1, else PCF+4.
REQ-025 ghr_F SHALL equal the current GHR register.
REQ-026 The update index SHALL be formed the same way as the lookup index, using update_pc_E and update_ghr_E; the live GHR is never used for the update index.
REQ-027 When update_en_E is high, the counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0.
REQ-028 When update_en_E and update_taken_E are both high, the entry SHALL be written with valid=1, the tag of update_pc_E and update_target_E.
REQ-029 A not-taken update SHALL leave valid, tag and target unchanged.
REQ-030 On update_en_E, the GHR SHALL become {GHR[HIST_BITS-2:0], update_taken_E}, non-speculative; for HIST_BITS=1 it becomes update_taken_E.
REQ-031 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update state; the new state is visible the next cycle.
REQ-032 On update_en_E, branch_count SHALL increment, holding at 0xFFFFFFFF.
REQ-033 On update_en_E && mispredict_E, mispredict_count SHALL increment, saturating at 0xFFFFFFFF.
REQ-034 mispredict_E SHALL be ignored when update_en_E is low.
REQ-035 All update effects SHALL take effect at the rising clk edge; update-to-lookup latency is 1 cycle.
REQ-036 With GSHARE=0 the GHR SHALL still shift, but it SHALL NOT affect indexing.

Reset
REQ-037 rst_n low SHALL asynchronously set every counter to 2'b01 (weakly not-taken), every valid bit to 0, GHR to 0, and both statistics counters to 0.
REQ-038 While rst_n is low, predict_taken_F SHALL be 0 and predicted_target_F SHALL be PCF+4.
REQ-039 Assertion mid-update SHALL discard that update; the first update is accepted on the first rising edge after rst_n deasserts.
REQ-040 Targets and tags MAY be left unreset, since valid=0 masks them.

Verification
REQ-041 The bench SHALL cover: after reset, PCF=0x100 -> predict_taken_F=0, predicted_target_F=0x104, ghr_F=0.
REQ-042 The bench SHALL cover: GSHARE=0, two taken updates pc=0x100, target 0x80 -> next cycle PCF=0x100 gives taken=1, target 0x80; a third taken update holds the counter at 3.
REQ-043 The bench SHALL cover: GSHARE=0, entry at counter=3, then three not-taken updates -> taken=0 after the second; the counter floors at 0; target is retained.
REQ-044 The bench SHALL cover: aliasing, PC 0x100 trained taken, lookup PC 0x100+4*ENTRIES (same index, different tag) -> taken=0, target=PC+4.
REQ-045 The bench SHALL cover: GSHARE=1, updates with update_ghr_E=6'b000001 vs 000000 on the same PC -> distinct entries trained, GHR shifts to 1,3,7 after taken updates.
REQ-046 The bench SHALL cover: update_en_E and mispredict_E with counters preloaded near 0xFFFFFFFF -> both saturate; rst_n pulse mid-stream -> all outputs return to reset values that cycle.
